layer_compositor: RTL and testbench

- Parametrised multi-layer successor to the single-pointer sprite overlay in the HDMI pixel path.
- Overlays NUM_LAYERS movable sprites on the Mandelbrot background. Each sprite's pixels come from an external synchronous ROM addressed by this block.
- Handles colour-key transparency and fixed-priority selection, and delays the sync/de signals to match.
- Sits between display_timings/palette and HDMI_generator on pix_clk. Exports the selected layer's position to the zoom unit.

---
 rtl/compositor_pkg.sv | 26 ++
 rtl/compositor_layer.sv | 91 +++++++++
 rtl/layer_compositor.sv | 161 ++++++++++++++++
 tb/tb_layer_compositor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compositor_pkg.sv
// Shared types and constants for the multi-layer sprite compositor.
package compositor_pkg;

   localparam int unsigned RGB_W   = 24;
   localparam int unsigned COORD_W = 16;
   localparam int unsigned IDX_W   = 3;

   localparam logic [RGB_W-1:0] KEY_RGB_DFLT = 24'hFF00FF;

   typedef logic [IDX_W-1:0] layer_idx_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/compositor_layer.sv
// One sprite layer: clamped position registers plus the stage-1 hit test
// and ROM address (u, v) registers.
module compositor_layer
   import compositor_pkg::*;
#(
   parameter int unsigned LAYER_IDX = 0,
   parameter int unsigned SPR_W     = 16,
   parameter int unsigned SPR_H     = 16,
   parameter int unsigned H_RES     = 800,
   parameter int unsigned V_RES     = 600,
   parameter int unsigned STEP      = 2
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [COORD_W-1:0]        i_x,
   input  logic [COORD_W-1:0]        i_y,
   input  logic                      mv_stb,
   input  logic                      mv_up,
   input  logic                      mv_down,
   input  logic                      mv_left,
   input  logic                      mv_right,
   input  logic                      fast,
   output logic [COORD_W-1:0]        pos_x,
   output logic [COORD_W-1:0]        pos_y,
   output logic                      hit,
   output logic [clog2(SPR_W)-1:0]   u,
   output logic [clog2(SPR_H)-1:0]   v
);

   localparam int unsigned UW    = clog2(SPR_W);
   localparam int unsigned VW    = clog2(SPR_H);
   localparam int unsigned CW1   = COORD_W + 1;
   localparam int unsigned X_MAX = H_RES - SPR_W;
   localparam int unsigned Y_MAX = V_RES - SPR_H;
   localparam int unsigned X_RST = (LAYER_IDX * 2 * SPR_W > X_MAX) ? X_MAX : LAYER_IDX * 2 * SPR_W;

   logic [COORD_W-1:0] step;
   logic [COORD_W-1:0] nxt_x;
   logic [COORD_W-1:0] nxt_y;
   logic [COORD_W:0]   sum_x;
   logic [COORD_W:0]   sum_y;
   logic [COORD_W:0]   end_x;
   logic [COORD_W:0]   end_y;
   logic               in_x;
   logic               in_y;
   logic               hit_c;

   // Next position (opposing requests cancel) and window test against the current position.
   always_comb begin
      step  = fast ? COORD_W'(4 * STEP) : COORD_W'(STEP);
      sum_x = {1'b0, pos_x} + CW1'(step);
      sum_y = {1'b0, pos_y} + CW1'(step);
      nxt_x = pos_x;
      nxt_y = pos_y;
      if (mv_left && !mv_right)
         nxt_x = (pos_x >= step) ? pos_x - step : '0;
      else if (mv_right && !mv_left)
         nxt_x = (sum_x > CW1'(X_MAX)) ? COORD_W'(X_MAX) : sum_x[COORD_W-1:0];
      if (mv_up && !mv_down)
         nxt_y = (pos_y >= step) ? pos_y - step : '0;
      else if (mv_down && !mv_up)
         nxt_y = (sum_y > CW1'(Y_MAX)) ? COORD_W'(Y_MAX) : sum_y[COORD_W-1:0];

      // Positions are never negative, so a negative coordinate can be rejected by its sign bit.
      end_x = {1'b0, pos_x} + CW1'(SPR_W);
      end_y = {1'b0, pos_y} + CW1'(SPR_H);
      in_x  = !i_x[COORD_W-1] && ({1'b0, i_x} >= {1'b0, pos_x}) && ({1'b0, i_x} < end_x);
      in_y  = !i_y[COORD_W-1] && ({1'b0, i_y} >= {1'b0, pos_y}) && ({1'b0, i_y} < end_y);
      hit_c = en && in_x && in_y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x <= COORD_W'(X_RST);
         pos_y <= '0;
         hit   <= 1'b0;
         u     <= '0;
         v     <= '0;
      end else begin
         if (mv_stb) begin
            pos_x <= nxt_x;
            pos_y <= nxt_y;
         end
         hit <= hit_c;
         u   <= hit_c ? UW'(i_x - pos_x) : '0;
         v   <= hit_c ? VW'(i_y - pos_y) : '0;
      end
   end

endmodule

// File: rtl/layer_compositor.sv
// Overlays NUM_LAYERS movable, colour-keyed sprites on the background pixel
// stream with a fixed 3-cycle latency; lowest layer index has priority.
module layer_compositor
   import compositor_pkg::*;
#(
   parameter int unsigned      NUM_LAYERS = 2,
   parameter int unsigned      SPR_W      = 16,
   parameter int unsigned      SPR_H      = 16,
   parameter int unsigned      H_RES      = 800,
   parameter int unsigned      V_RES      = 600,
   parameter int unsigned      STEP       = 2,
   parameter logic [RGB_W-1:0] KEY_RGB    = KEY_RGB_DFLT,
   parameter logic             VS_POL     = 1'b1
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [COORD_W-1:0]                   i_x,
   input  logic [COORD_W-1:0]                   i_y,
   input  logic                                 i_de,
   input  logic                                 i_hs,
   input  logic                                 i_vs,
   input  logic [RGB_W-1:0]                     i_bg_rgb,
   input  logic [NUM_LAYERS-1:0]                layer_en,
   input  logic [IDX_W-1:0]                     sel,
   input  logic                                 mv_up,
   input  logic                                 mv_down,
   input  logic                                 mv_left,
   input  logic                                 mv_right,
   input  logic                                 fast,
   output logic [NUM_LAYERS*clog2(SPR_W)-1:0]   o_spr_u,
   output logic [NUM_LAYERS*clog2(SPR_H)-1:0]   o_spr_v,
   input  logic [NUM_LAYERS*RGB_W-1:0]          i_spr_rgb,
   output logic [RGB_W-1:0]                     o_rgb,
   output logic                                 o_de,
   output logic                                 o_hs,
   output logic                                 o_vs,
   output logic                                 o_hit,
   output logic [IDX_W-1:0]                     o_hit_layer,
   output logic [COORD_W-1:0]                   o_sel_x,
   output logic [COORD_W-1:0]                   o_sel_y
);

   localparam int unsigned UW = clog2(SPR_W);
   localparam int unsigned VW = clog2(SPR_H);

   logic                  vs_q;
   logic                  mv_edge;
   logic [COORD_W-1:0]    pos_x [NUM_LAYERS];
   logic [COORD_W-1:0]    pos_y [NUM_LAYERS];
   logic [NUM_LAYERS-1:0] hit1;
   logic [NUM_LAYERS-1:0] hit2;
   logic [1:0]            de_d;
   logic [1:0]            hs_d;
   logic [1:0]            vs_d;
   rgb_t                  bg1;
   rgb_t                  bg2;
   logic                  win;
   layer_idx_t            win_idx;
   rgb_t                  win_rgb;
   logic [COORD_W-1:0]    sel_x;
   logic [COORD_W-1:0]    sel_y;

   // Movement is applied only on the cycle vsync becomes active.
   assign mv_edge = (i_vs == VS_POL) && (vs_q != VS_POL);

   for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
      compositor_layer #(
         .LAYER_IDX (k),
         .SPR_W     (SPR_W),
         .SPR_H     (SPR_H),
         .H_RES     (H_RES),
         .V_RES     (V_RES),
         .STEP      (STEP)
      ) u_layer (
         .clk      (clk),
         .rst      (rst),
         .en       (layer_en[k]),
         .i_x      (i_x),
         .i_y      (i_y),
         .mv_stb   (mv_edge && (sel == IDX_W'(k))),
         .mv_up    (mv_up),
         .mv_down  (mv_down),
         .mv_left  (mv_left),
         .mv_right (mv_right),
         .fast     (fast),
         .pos_x    (pos_x[k]),
         .pos_y    (pos_y[k]),
         .hit      (hit1[k]),
         .u        (o_spr_u[k*UW +: UW]),
         .v        (o_spr_v[k*VW +: VW])
      );
   end

   // Lowest-index visible layer wins; scanning downwards lets it overwrite higher ones.
   always_comb begin
      win     = 1'b0;
      win_idx = '0;
      win_rgb = bg2;
      for (int k = int'(NUM_LAYERS) - 1; k >= 0; k--) begin
         if (hit2[k] && (i_spr_rgb[k*RGB_W +: RGB_W] != KEY_RGB)) begin
            win     = 1'b1;
            win_idx = IDX_W'(k);
            win_rgb = i_spr_rgb[k*RGB_W +: RGB_W];
         end
      end
   end

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int k = 0; k < int'(NUM_LAYERS); k++) begin
         if (sel == IDX_W'(k)) begin
            sel_x = pos_x[k];
            sel_y = pos_y[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q        <= ~VS_POL;
         de_d        <= '0;
         hs_d        <= '0;
         vs_d        <= '0;
         bg1         <= '0;
         bg2         <= '0;
         hit2        <= '0;
         o_rgb       <= '0;
         o_de        <= 1'b0;
         o_hs        <= 1'b0;
         o_vs        <= 1'b0;
         o_hit       <= 1'b0;
         o_hit_layer <= '0;
         o_sel_x     <= '0;
         o_sel_y     <= '0;
      end else begin
         vs_q    <= i_vs;
         de_d    <= {de_d[0], i_de};
         hs_d    <= {hs_d[0], i_hs};
         vs_d    <= {vs_d[0], i_vs};
         bg1     <= i_bg_rgb;
         bg2     <= bg1;
         hit2    <= hit1;
         o_de    <= de_d[1];
         o_hs    <= hs_d[1];
         o_vs    <= vs_d[1];
         o_sel_x <= sel_x;
         o_sel_y <= sel_y;
         if (de_d[1]) begin
            o_rgb       <= win_rgb;
            o_hit       <= win;
            o_hit_layer <= win_idx;
         end else begin
            o_rgb       <= '0;
            o_hit       <= 1'b0;
            o_hit_layer <= '0;
         end
      end
   end

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized bench for layer_compositor against a per-pixel reference model,
// plus directed reset, latency, priority, clamp and vsync-edge scenarios.
module tb_layer_compositor;

   localparam int N     = 2;
   localparam int SW    = 16;
   localparam int SH    = 16;
   localparam int X_MAX = 800 - SW;
   localparam int Y_MAX = 600 - SH;
   localparam logic [23:0] KEY = 24'hFF00FF;

   logic            clk = 1'b0;
   logic            rst;
   logic [15:0]     i_x, i_y;
   logic            i_de, i_hs, i_vs;
   logic [23:0]     i_bg_rgb;
   logic [N-1:0]    layer_en;
   logic [2:0]      sel;
   logic            mv_up, mv_down, mv_left, mv_right, fast;
   logic [N*4-1:0]  o_spr_u, o_spr_v;
   logic [N*24-1:0] i_spr_rgb;
   logic [23:0]     o_rgb;
   logic            o_de, o_hs, o_vs, o_hit;
   logic [2:0]      o_hit_layer;
   logic [15:0]     o_sel_x, o_sel_y;

   always #5 clk = ~clk;

   layer_compositor #(.NUM_LAYERS(N)) dut (
      .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .i_de(i_de), .i_hs(i_hs), .i_vs(i_vs),
      .i_bg_rgb(i_bg_rgb), .layer_en(layer_en), .sel(sel),
      .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right), .fast(fast),
      .o_spr_u(o_spr_u), .o_spr_v(o_spr_v), .i_spr_rgb(i_spr_rgb),
      .o_rgb(o_rgb), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs),
      .o_hit(o_hit), .o_hit_layer(o_hit_layer), .o_sel_x(o_sel_x), .o_sel_y(o_sel_y)
   );

   // Sprite ROMs with a one-cycle synchronous read.
   logic [23:0] rom [N][SH][SW];
   always @(posedge clk)
      for (int k = 0; k < N; k++)
         i_spr_rgb[k*24 +: 24] <= rom[k][o_spr_v[k*4 +: 4]][o_spr_u[k*4 +: 4]];

   typedef struct {
      logic [23:0] rgb;
      bit          hit;
      bit [2:0]    lyr;
      bit          de, hs, vs;
   } exp_t;

   // Stimulus for the next cycle
   int          s_x, s_y;
   bit          s_de, s_hs, s_vs, s_rst, s_fast, s_up, s_down, s_left, s_right;
   logic [23:0] s_bg;
   logic [N-1:0] s_en;
   logic [2:0]  s_sel;

   // Reference model state
   int           px [N];
   int           py [N];
   bit           prev_vs;
   exp_t         q[$];
   logic [N*4-1:0] eu, ev;
   logic [15:0]  esx, esy;
   bit           have_prev;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_t z;
      z = '{default: 0};
      for (int k = 0; k < N; k++) begin
         px[k] = (k * 2 * SW > X_MAX) ? X_MAX : k * 2 * SW;
         py[k] = 0;
      end
      prev_vs = 1'b0;
      q.delete();
      repeat (3) q.push_back(z);
      eu = '0; ev = '0; esx = '0; esy = '0;
   endtask

   // One pixel: which layers cover it, which visible one has the lowest index, then vsync movement.
   task automatic model_cycle();
      exp_t e;
      bit   found;
      int   u, v, sidx, st;
      e = '{default: 0};
      e.de = s_de; e.hs = s_hs; e.vs = s_vs;
      eu = '0; ev = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (s_en[k] && s_x >= px[k] && s_x < px[k] + SW && s_y >= py[k] && s_y < py[k] + SH) begin
            u = s_x - px[k];
            v = s_y - py[k];
            eu[k*4 +: 4] = 4'(u);
            ev[k*4 +: 4] = 4'(v);
            if (!found && rom[k][v][u] != KEY) begin
               found = 1'b1; e.rgb = rom[k][v][u]; e.hit = 1'b1; e.lyr = 3'(k);
            end
         end
      end
      if (!found) e.rgb = s_bg;
      if (!s_de) begin e.rgb = '0; e.hit = 1'b0; end
      q.push_back(e);
      sidx = int'(s_sel);
      esx = (sidx < N) ? 16'(px[sidx]) : 16'd0;
      esy = (sidx < N) ? 16'(py[sidx]) : 16'd0;
      if (s_vs && !prev_vs && sidx < N) begin
         st = s_fast ? 8 : 2;
         if (s_left && !s_right)  px[sidx] = (px[sidx] - st < 0) ? 0 : px[sidx] - st;
         if (s_right && !s_left)  px[sidx] = (px[sidx] + st > X_MAX) ? X_MAX : px[sidx] + st;
         if (s_up && !s_down)     py[sidx] = (py[sidx] - st < 0) ? 0 : py[sidx] - st;
         if (s_down && !s_up)     py[sidx] = (py[sidx] + st > Y_MAX) ? Y_MAX : py[sidx] + st;
      end
      prev_vs = s_vs;
   endtask

   // Advance one clock: compare DUT outputs with the model, then drive the next stimulus.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() == 3) begin
         e = q.pop_front();
         check_eq("rgb", 32'(o_rgb), 32'(e.rgb));
         check_eq("hit", 32'(o_hit), 32'(e.hit));
         check_eq("de",  32'(o_de),  32'(e.de));
         check_eq("hs",  32'(o_hs),  32'(e.hs));
         check_eq("vs",  32'(o_vs),  32'(e.vs));
         if (e.de) check_eq("hit_layer", 32'(o_hit_layer), 32'(e.lyr));
      end
      if (have_prev) begin
         check_eq("spr_u", 32'(o_spr_u), 32'(eu));
         check_eq("spr_v", 32'(o_spr_v), 32'(ev));
         check_eq("sel_x", 32'(o_sel_x), 32'(esx));
         check_eq("sel_y", 32'(o_sel_y), 32'(esy));
      end
      rst = s_rst; i_x = 16'(s_x); i_y = 16'(s_y); i_de = s_de; i_hs = s_hs; i_vs = s_vs;
      i_bg_rgb = s_bg; layer_en = s_en; sel = s_sel;
      mv_up = s_up; mv_down = s_down; mv_left = s_left; mv_right = s_right; fast = s_fast;
      if (s_rst) model_reset();
      else       model_cycle();
      have_prev = 1'b1;
   endtask

   task automatic vs_pulse();
      s_vs = 1'b1; step();
      s_vs = 1'b0; step();
      step();
   endtask

   task automatic clr_moves();
      s_up = 0; s_down = 0; s_left = 0; s_right = 0; s_fast = 0;
   endtask

   // Drive one active pixel, idle for three cycles and check the composited result.
   task automatic pix_check(input string tag, input int x, input int y, input logic [23:0] bg,
                            input logic [23:0] rgb, input bit hit, input bit [2:0] lyr);
      s_x = x; s_y = y; s_bg = bg; s_de = 1'b1;
      step();
      s_de = 1'b0;
      repeat (3) step();
      check_eq({tag, "_rgb"}, 32'(o_rgb), 32'(rgb));
      check_eq({tag, "_hit"}, 32'(o_hit), 32'(hit));
      if (hit) check_eq({tag, "_layer"}, 32'(o_hit_layer), 32'(lyr));
   endtask

   initial begin
      int k;
      rst = 1'b1; i_x = '0; i_y = '0; i_de = 0; i_hs = 0; i_vs = 0; i_bg_rgb = '0;
      layer_en = '0; sel = '0; mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0; fast = 0;
      have_prev = 1'b0;
      s_x = 0; s_y = 0; s_de = 0; s_hs = 0; s_vs = 0; s_bg = '0; s_en = '0; s_sel = '0;
      clr_moves();

      for (int l = 0; l < N; l++)
         for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
               rom[l][r][c] = ($urandom_range(0, 9) < 3) ? KEY : 24'($urandom);
      rom[0][3][5]  = 24'h123456;
      rom[0][2][10] = KEY; rom[1][2][2] = 24'h00FF00;
      rom[0][2][11] = KEY; rom[1][2][3] = KEY;
      rom[0][2][12] = KEY; rom[1][2][4] = 24'hABCDEF;

      // Reset and the reset position of layer 1
      s_rst = 1'b1; repeat (2) step();
      s_rst = 1'b0; s_sel = 3'd1; step(); step();
      check_eq("rst_sel_x", 32'(o_sel_x), 32'd32);
      check_eq("rst_sel_y", 32'(o_sel_y), 32'd0);
      check_eq("rst_rgb", 32'(o_rgb), 32'd0);
      check_eq("rst_de", 32'(o_de), 32'd0);

      // Latency and ROM addressing
      s_en = 2'b01; s_sel = 3'd0; s_de = 1; s_x = 5; s_y = 3; s_bg = 24'h000080;
      step();
      s_de = 0; step();
      check_eq("lat_u", 32'(o_spr_u[3:0]), 32'd5);
      check_eq("lat_v", 32'(o_spr_v[3:0]), 32'd3);
      repeat (2) step();
      check_eq("lat_rgb", 32'(o_rgb), 32'h123456);
      check_eq("lat_hit", 32'(o_hit), 32'd1);
      check_eq("lat_layer", 32'(o_hit_layer), 32'd0);

      // Overlap layer 1 onto layer 0 (x=8), then key/priority cases
      s_sel = 3'd1; s_left = 1; s_fast = 1;
      repeat (3) vs_pulse();
      clr_moves();
      s_en = 2'b11;
      pix_check("prio", 10, 2, 24'h111111, 24'h00FF00, 1'b1, 3'd1);
      pix_check("bothkey", 11, 2, 24'h222222, 24'h222222, 1'b0, 3'd0);
      s_en = 2'b01;
      pix_check("disabled", 12, 2, 24'h333333, 24'h333333, 1'b0, 3'd0);

      // Clamping of layer 0
      s_sel = 3'd0; s_left = 1;
      repeat (3) vs_pulse();
      check_eq("clamp_left", 32'(o_sel_x), 32'd0);
      clr_moves(); s_right = 1; s_fast = 1;
      repeat (100) vs_pulse();
      check_eq("clamp_right", 32'(o_sel_x), 32'd784);
      clr_moves(); s_down = 1; s_fast = 1;
      repeat (100) vs_pulse();
      check_eq("clamp_down", 32'(o_sel_y), 32'd584);
      clr_moves(); s_left = 1; s_right = 1; s_fast = 1;
      repeat (3) vs_pulse();
      check_eq("lr_cancel", 32'(o_sel_x), 32'd784);
      clr_moves(); s_left = 1; s_fast = 1;
      repeat (10) vs_pulse();
      check_eq("left_fast", 32'(o_sel_x), 32'd704);

      // Long vsync moves only once
      clr_moves(); s_right = 1;
      s_vs = 1'b1; repeat (500) step();
      s_vs = 1'b0; step(); step();
      check_eq("vs_held", 32'(o_sel_x), 32'd706);
      clr_moves();

      // Reset during active video over the moved sprite
      s_de = 1; s_x = 710; s_y = 590; s_bg = 24'h0000FF;
      repeat (4) step();
      s_rst = 1'b1; s_sel = 3'd1; step();
      s_rst = 1'b0; step();
      check_eq("mid_rst_rgb", 32'(o_rgb), 32'd0);
      check_eq("mid_rst_de", 32'(o_de), 32'd0);
      check_eq("mid_rst_hit", 32'(o_hit), 32'd0);
      step();
      check_eq("mid_rst_sel_x", 32'(o_sel_x), 32'd32);
      repeat (4) begin
         step();
         check_eq("mid_rst_stale_hit", 32'(o_hit), 32'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         s_rst = ($urandom_range(0, 399) == 0);
         s_de  = ($urandom_range(0, 9) != 0);
         s_hs  = 1'($urandom);
         if ($urandom_range(0, 19) == 0) s_vs = !s_vs;
         s_en  = N'($urandom);
         s_sel = 3'($urandom_range(0, 4));
         s_up = 1'($urandom); s_down = 1'($urandom);
         s_left = 1'($urandom); s_right = 1'($urandom); s_fast = 1'($urandom);
         s_bg  = 24'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            s_x = int'($urandom_range(0, 1000)) - 100;
            s_y = int'($urandom_range(0, 800)) - 100;
         end else begin
            k   = int'($urandom_range(0, N - 1));
            s_x = px[k] + int'($urandom_range(0, 24)) - 4;
            s_y = py[k] + int'($urandom_range(0, 24)) - 4;
         end
         step();
      end
      s_rst = 0; s_de = 0; clr_moves();
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
